// File: rtl/stack_mem_pkg.sv
// Shared definitions for the stack processor memory initiator: command
// encoding, FSM states and default stack bounds.
package stack_mem_pkg;

  typedef enum logic [1:0] {
    OpLoad  = 2'd0,
    OpStore = 2'd1,
    OpPush  = 2'd2,
    OpPop   = 2'd3
  } stack_op_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StIssue  = 3'd1,
    StSettle = 3'd2,
    StWait   = 3'd3,
    StDone   = 3'd4
  } stack_state_e;

  localparam logic [15:0] DefaultStackTop   = 16'h00FF;
  localparam logic [15:0] DefaultStackLimit = 16'h0080;

  // STORE and PUSH are the only ops that strobe the memory write.
  function automatic logic op_is_write(stack_op_e op);
    return (op == OpStore) || (op == OpPush);
  endfunction

endpackage

// File: rtl/stack_mem_master.sv
// Memory initiator for the stack processor: owns the stack pointer, checks stack
// bounds locally and turns the memory's self-timed ready into a one-cycle response.
module stack_mem_master
  import stack_mem_pkg::*;
#(
  parameter logic [15:0] STACK_TOP   = DefaultStackTop,
  parameter logic [15:0] STACK_LIMIT = DefaultStackLimit
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] sp,
  output logic [15:0] mem_addr,
  output logic        mem_w,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [15:0] SpEmpty = STACK_TOP + 16'd1;

  stack_state_e state_q, state_d;
  stack_op_e    op_q, op_d;
  logic         err_q, err_d;
  logic [15:0]  sp_q, sp_d;
  logic [15:0]  mem_addr_q, mem_addr_d;
  logic [15:0]  mem_wdata_q, mem_wdata_d;
  logic [15:0]  rsp_data_q, rsp_data_d;

  stack_op_e cmd_op_e;
  logic      cmd_bad;

  assign cmd_op_e = stack_op_e'(cmd_op);

  // Illegal stack accesses are caught here so they never reach the memory.
  assign cmd_bad = ((cmd_op_e == OpPush) && (sp_q == STACK_LIMIT)) ||
                   ((cmd_op_e == OpPop)  && (sp_q == SpEmpty));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    err_d       = err_q;
    sp_d        = sp_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d = cmd_op_e;
          if (cmd_bad) begin
            err_d      = 1'b1;
            rsp_data_d = 16'h0000;
            state_d    = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = StIssue;
            unique case (cmd_op_e)
              OpLoad: begin
                mem_addr_d = cmd_addr;
              end
              OpStore: begin
                mem_addr_d  = cmd_addr;
                mem_wdata_d = cmd_data;
              end
              OpPush: begin
                sp_d        = sp_q - 16'd1;
                mem_addr_d  = sp_q - 16'd1;
                mem_wdata_d = cmd_data;
              end
              OpPop: begin
                mem_addr_d = sp_q;
              end
              default: ;
            endcase
          end
        end
      end
      StIssue: begin
        state_d = StSettle;
      end
      // mem_ready may still reflect the previous access here, so it is not looked at.
      StSettle: begin
        state_d = StWait;
      end
      StWait: begin
        if (mem_ready) begin
          rsp_data_d = op_is_write(op_q) ? mem_wdata_q : mem_rdata;
          if (op_q == OpPop) begin
            sp_d = sp_q + 16'd1;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= OpLoad;
      err_q       <= 1'b0;
      sp_q        <= SpEmpty;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      rsp_data_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      err_q       <= err_d;
      sp_q        <= sp_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Gated by rst_n so the core sees no acceptance while reset is held.
  assign cmd_ready = (state_q == StIdle) && rst_n;
  assign rsp_valid = (state_q == StDone);
  assign rsp_err   = (state_q == StDone) && err_q;
  assign rsp_data  = rsp_data_q;
  assign sp        = sp_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_w     = (state_q == StIssue) && op_is_write(op_q);

endmodule

// File: tb/tb_stack_mem_master.sv
// Directed bench for stack_mem_master with a behavioural self-timed memory that
// drops ready for a programmable number of cycles whenever address changes or on a write.
module tb_stack_mem_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] sp;
  logic [15:0] mem_addr;
  logic        mem_w;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int n_cmp = 0;
  int n_err = 0;

  stack_mem_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .sp        (sp),
    .mem_addr  (mem_addr),
    .mem_w     (mem_w),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: zero-initialised, not affected by the master's reset.
  logic [15:0] mem [0:65535];
  logic [15:0] last_addr;
  int          mem_lat = 1;
  int          busy_cnt;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    last_addr = 16'h0000;
    mem_ready = 1'b1;
    mem_rdata = 16'h0000;
    busy_cnt  = 0;
  end

  always @(posedge clk) begin
    if (mem_w) mem[mem_addr] <= mem_wdata;
    if (mem_w || (mem_addr != last_addr)) begin
      last_addr <= mem_addr;
      mem_ready <= 1'b0;
      busy_cnt  <= mem_lat - 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end else if (!mem_ready) begin
      mem_ready <= 1'b1;
      mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
  task automatic do_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic re, output int lat,
                        output int wcnt, output int wcyc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat  = -1;
    wcnt = 0;
    wcyc = -1;
    rd   = 16'hxxxx;
    re   = 1'bx;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_w) begin
        wcnt++;
        if (wcyc < 0) wcyc = c;
      end
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_data;
        re  = rsp_err;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [15:0] rd;
  logic        re;
  int          lat, wcnt, wcyc, seen;
  logic [15:0] addr_before;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 16'h0000;
    cmd_data  = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_sp", sp, 16'h0100);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_w", mem_w, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_release_ready", cmd_ready, 1);

    // STORE then LOAD
    do_cmd(2'd1, 16'h0010, 16'hBEEF, rd, re, lat, wcnt, wcyc);
    check_eq("store_lat", lat, 4);
    check_eq("store_wcnt", wcnt, 1);
    check_eq("store_wcyc", wcyc, 1);
    check_eq("store_data", {re, rd}, {1'b0, 16'hBEEF});
    check_eq("store_mem", mem[16'h0010], 16'hBEEF);
    check_eq("idle_ready", cmd_ready, 1);
    do_cmd(2'd0, 16'h0010, 16'h0000, rd, re, lat, wcnt, wcyc);
    check_eq("load_lat", lat, 4);
    check_eq("load_wcnt", wcnt, 0);
    check_eq("load_data", {re, rd}, {1'b0, 16'hBEEF});

    // PUSH / POP sequence
    apply_reset();
    do_cmd(2'd2, 16'h0000, 16'h1111, rd, re, lat, wcnt, wcyc);
    check_eq("push1_sp", sp, 16'h00FF);
    check_eq("push1_rsp", {re, rd}, {1'b0, 16'h1111});
    check_eq("push1_wcnt", wcnt, 1);
    do_cmd(2'd2, 16'h0000, 16'h2222, rd, re, lat, wcnt, wcyc);
    check_eq("push2_sp", sp, 16'h00FE);
    check_eq("push2_mem", mem[16'h00FE], 16'h2222);
    do_cmd(2'd3, 16'h0000, 16'h0000, rd, re, lat, wcnt, wcyc);
    check_eq("pop1_data", {re, rd}, {1'b0, 16'h2222});
    check_eq("pop1_lat", lat, 4);
    check_eq("pop1_sp", sp, 16'h00FF);
    do_cmd(2'd3, 16'h0000, 16'h0000, rd, re, lat, wcnt, wcyc);
    check_eq("pop2_data", {re, rd}, {1'b0, 16'h1111});
    check_eq("pop2_sp", sp, 16'h0100);

    // Underflow
    addr_before = mem_addr;
    do_cmd(2'd3, 16'h0000, 16'h0000, rd, re, lat, wcnt, wcyc);
    check_eq("under_lat", lat, 1);
    check_eq("under_rsp", {re, rd}, {1'b1, 16'h0000});
    check_eq("under_sp", sp, 16'h0100);
    check_eq("under_wcnt", wcnt, 0);
    check_eq("under_addr", mem_addr, addr_before);

    // Fill to the limit, then overflow
    for (int i = 0; i < 128; i++) begin
      do_cmd(2'd2, 16'h0000, 16'hA000 + 16'(i), rd, re, lat, wcnt, wcyc);
    end
    check_eq("fill_sp", sp, 16'h0080);
    check_eq("fill_mem", mem[16'h0080], 16'hA07F);
    addr_before = mem_addr;
    do_cmd(2'd2, 16'h0000, 16'hDEAD, rd, re, lat, wcnt, wcyc);
    check_eq("over_lat", lat, 1);
    check_eq("over_rsp", {re, rd}, {1'b1, 16'h0000});
    check_eq("over_sp", sp, 16'h0080);
    check_eq("over_wcnt", wcnt, 0);
    check_eq("over_addr", mem_addr, addr_before);
    check_eq("over_mem", mem[16'h007F], 16'h0000);
    do_cmd(2'd3, 16'h0000, 16'h0000, rd, re, lat, wcnt, wcyc);
    check_eq("top_pop_data", {re, rd}, {1'b0, 16'hA07F});
    check_eq("top_pop_sp", sp, 16'h0081);

    // Same-address LOAD twice, ready never drops on the second
    do_cmd(2'd0, 16'h0010, 16'h0000, rd, re, lat, wcnt, wcyc);
    check_eq("rl1_data", {re, rd}, {1'b0, 16'hBEEF});
    check_eq("rl1_lat", lat, 4);
    do_cmd(2'd0, 16'h0010, 16'h0000, rd, re, lat, wcnt, wcyc);
    check_eq("rl2_data", {re, rd}, {1'b0, 16'hBEEF});
    check_eq("rl2_lat", lat, 4);

    // Slow memory stretches WAIT
    mem_lat = 3;
    do_cmd(2'd0, 16'h0081, 16'h0000, rd, re, lat, wcnt, wcyc);
    check_eq("slow_data", {re, rd}, {1'b0, 16'hA07E});
    check_eq("slow_lat", lat, 6);

    // Reset during WAIT of a POP
    apply_reset();
    mem_lat = 1;
    do_cmd(2'd2, 16'h0000, 16'h5555, rd, re, lat, wcnt, wcyc);
    check_eq("abort_push_sp", sp, 16'h00FF);
    mem_lat   = 3;
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    seen  = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check_eq("abort_no_rsp", seen, 0);
    check_eq("abort_sp", sp, 16'h0100);
    check_eq("abort_mem_w", mem_w, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", cmd_ready, 1);
    mem_lat = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
